// File: rtl/ps2_kbd_pkg.sv
// ---------------------------------------------------------------------------
// ps2_kbd_pkg
// Shared definitions for the PS/2 key sequencer slice: scan-code constants,
// sequencer FSM state encoding, the decoded key-event record and a small
// helper that recognises prefix bytes.
// No ports (package).
// ---------------------------------------------------------------------------
package ps2_kbd_pkg;

   localparam logic [7:0] SC_BREAK  = 8'hF0;
   localparam logic [7:0] SC_EXT    = 8'hE0;
   localparam logic [7:0] SC_LSHIFT = 8'h12;
   localparam logic [7:0] SC_RSHIFT = 8'h59;
   localparam logic [7:0] SC_CTRL   = 8'h14;
   localparam logic [7:0] SC_ALT    = 8'h11;
   localparam logic [7:0] SC_CAPS   = 8'h58;

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_POP    = 2'd1,
      S_DECODE = 2'd2,
      S_EMIT   = 2'd3
   } state_t;

   // One folded key event: prefixes removed, their meaning kept as flags.
   typedef struct packed {
      logic [7:0] code;
      logic       ext;
      logic       brk;
   } key_evt_t;

   function automatic logic is_prefix(input logic [7:0] c);
      return (c == SC_BREAK) || (c == SC_EXT);
   endfunction

endpackage

// File: rtl/ps2_key_sequencer_if.sv
// ---------------------------------------------------------------------------
// ps2_key_sequencer_if
// Bundles the two handshakes around the key sequencer:
//   receiver side : kb_data, kb_ready (FIFO head / non-empty), kb_nextdata_n
//                   (active-low pop strobe back to the receiver)
//   event side    : evt_valid/evt_ready handshake carrying evt_code,
//                   evt_ext, evt_break
// master = the sequencer, slave = the surrounding receiver + consumer.
// ---------------------------------------------------------------------------
interface ps2_key_sequencer_if;

   logic [7:0] kb_data;
   logic       kb_ready;
   logic       kb_nextdata_n;

   logic       evt_valid;
   logic       evt_ready;
   logic [7:0] evt_code;
   logic       evt_ext;
   logic       evt_break;

   modport master (
      input  kb_data, kb_ready, evt_ready,
      output kb_nextdata_n, evt_valid, evt_code, evt_ext, evt_break
   );

   modport slave (
      output kb_data, kb_ready, evt_ready,
      input  kb_nextdata_n, evt_valid, evt_code, evt_ext, evt_break
   );

endinterface

// File: rtl/ps2_mod_tracker.sv
// ---------------------------------------------------------------------------
// ps2_mod_tracker
// Holds modifier and caps-lock state, updated from each folded key event.
// Ports:
//   clk, clrn        clock, asynchronous active-low reset
//   strobe           one-cycle pulse: a key event is being decoded
//   code, ext, brk   the event (scan code, E0-prefixed, release)
//   mod_shift        left or right shift held (non-extended codes only)
//   mod_ctrl         ctrl held (extended or not)
//   mod_alt          alt held (extended or not)
//   caps_lock        toggles on every caps make
// ---------------------------------------------------------------------------
module ps2_mod_tracker
   import ps2_kbd_pkg::*;
(
   input  logic       clk,
   input  logic       clrn,
   input  logic       strobe,
   input  logic [7:0] code,
   input  logic       ext,
   input  logic       brk,
   output logic       mod_shift,
   output logic       mod_ctrl,
   output logic       mod_alt,
   output logic       caps_lock
);

   logic lshift_q, rshift_q, ctrl_q, alt_q, caps_q;

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples pre-edge values regardless of statement order.
   always_ff @(posedge clk or negedge clrn) begin
      if (!clrn) begin
         lshift_q <= 1'b0;
         rshift_q <= 1'b0;
         ctrl_q   <= 1'b0;
         alt_q    <= 1'b0;
         caps_q   <= 1'b0;
      end else if (strobe) begin
         // Make sets, break clears; the two shifts are kept apart so that
         // releasing one while the other is held keeps shift asserted.
         if (!ext && code == SC_LSHIFT) lshift_q <= !brk;
         if (!ext && code == SC_RSHIFT) rshift_q <= !brk;
         if (code == SC_CTRL)           ctrl_q   <= !brk;
         if (code == SC_ALT)            alt_q    <= !brk;
         if (code == SC_CAPS && !brk)   caps_q   <= !caps_q;
      end
   end

   assign mod_shift = lshift_q | rshift_q;
   assign mod_ctrl  = ctrl_q;
   assign mod_alt   = alt_q;
   assign caps_lock = caps_q;

endmodule

// File: rtl/ps2_key_sequencer.sv
// ---------------------------------------------------------------------------
// ps2_key_sequencer
// Drains scan-code bytes from the PS/2 receiver FIFO, folds E0/F0 prefixes
// into single key events, tracks modifiers and presents events on a
// valid/ready port. Back-pressure on the event port stalls popping, so the
// receiver FIFO absorbs bytes meanwhile.
// Parameters:
//   CNT_W        width of the wrapping make-event counter key_cnt
//   TIMEOUT_CYC  idle cycles after a prefix before the pending prefix drops
// Ports:
//   clk, clrn    clock, asynchronous active-low reset
//   bus          ps2_key_sequencer_if.master (receiver pop + event handshake)
//   mod_shift, mod_ctrl, mod_alt, caps_lock   modifier state
//   key_cnt      make events emitted, modulo 2^CNT_W
// Build option:
//   PS2_REPEAT_FILTER_EN  swallow typematic repeats of the last make key
// ---------------------------------------------------------------------------
module ps2_key_sequencer
   import ps2_kbd_pkg::*;
#(
   parameter int CNT_W       = 8,
   parameter int TIMEOUT_CYC = 500000
) (
   input  logic                  clk,
   input  logic                  clrn,
   ps2_key_sequencer_if.master   bus,
   output logic                  mod_shift,
   output logic                  mod_ctrl,
   output logic                  mod_alt,
   output logic                  caps_lock,
   output logic [CNT_W-1:0]      key_cnt
);

   localparam int TO_W = $clog2(TIMEOUT_CYC + 1);

   state_t           state, state_nxt;
   logic [7:0]       code_r;
   logic             brk_f, ext_f;
   key_evt_t         dec_evt, pend_q, evt_q;
   logic             evt_valid_q;
   logic             nextdata_n_q;
   logic [CNT_W-1:0] cnt_q;
   logic [TO_W-1:0]  to_cnt;

   logic do_pop, do_evt, do_load, repeat_hit, to_run, to_hit;

   assign dec_evt = '{code: code_r, ext: ext_f, brk: brk_f};

`ifdef PS2_REPEAT_FILTER_EN
   logic       lm_valid;
   logic [8:0] lm_key;

   // A make that matches the remembered key is a typematic repeat.
   assign repeat_hit = !brk_f && lm_valid && (lm_key == {ext_f, code_r});

   always_ff @(posedge clk or negedge clrn) begin
      if (!clrn) begin
         lm_valid <= 1'b0;
         lm_key   <= '0;
      end else if (do_evt) begin
         if (!brk_f) begin
            lm_valid <= 1'b1;
            lm_key   <= {ext_f, code_r};
         end else if (lm_key == {ext_f, code_r}) begin
            lm_valid <= 1'b0;
         end
      end
   end
`else
   assign repeat_hit = 1'b0;
`endif

   // ---------------- FSM: state register ----------------
   always_ff @(posedge clk or negedge clrn) begin
      if (!clrn) state <= S_IDLE;
      else       state <= state_nxt;
   end

   // ---------------- FSM: next state and control strobes ----------------
   // NOTE: every always_comb output gets a default first so no path can
   // leave it unassigned and infer a latch.
   always_comb begin
      state_nxt = state;
      do_pop    = 1'b0;
      do_evt    = 1'b0;
      do_load   = 1'b0;
      case (state)
         S_IDLE: begin
            if (bus.kb_ready) begin
               do_pop    = 1'b1;
               state_nxt = S_POP;
            end
         end
         S_POP:    state_nxt = S_DECODE;
         S_DECODE: begin
            if (is_prefix(code_r) || repeat_hit) begin
               state_nxt = S_IDLE;
            end else begin
               do_evt    = 1'b1;
               state_nxt = S_EMIT;
            end
         end
         S_EMIT: begin
            if (!evt_valid_q || bus.evt_ready) begin
               do_load   = 1'b1;
               state_nxt = S_IDLE;
            end
         end
         default: state_nxt = S_IDLE;
      endcase
   end

   // Prefix timeout only runs while parked in IDLE with nothing to read.
   assign to_run = (brk_f | ext_f) && (state == S_IDLE) && !bus.kb_ready;
   assign to_hit = to_run && (to_cnt == TO_W'(TIMEOUT_CYC - 1));

   // ---------------- datapath ----------------
   // NOTE: all registers, data included, are reset because every output
   // has a defined value straight out of reset.
   always_ff @(posedge clk or negedge clrn) begin
      if (!clrn) begin
         code_r       <= '0;
         brk_f        <= 1'b0;
         ext_f        <= 1'b0;
         pend_q       <= '0;
         evt_q        <= '0;
         evt_valid_q  <= 1'b0;
         nextdata_n_q <= 1'b1;
         cnt_q        <= '0;
         to_cnt       <= '0;
      end else begin
         // Low for exactly the cycle after the pop decision.
         nextdata_n_q <= !do_pop;
         if (do_pop) code_r <= bus.kb_data;

         if (state == S_DECODE) begin
            if (code_r == SC_BREAK) begin
               brk_f <= 1'b1;
            end else if (code_r == SC_EXT) begin
               ext_f <= 1'b1;
            end else begin
               brk_f <= 1'b0;
               ext_f <= 1'b0;
            end
         end else if (to_hit) begin
            brk_f <= 1'b0;
            ext_f <= 1'b0;
         end

         if (do_pop || to_hit) to_cnt <= '0;
         else if (to_run)      to_cnt <= to_cnt + TO_W'(1);

         if (do_evt) begin
            pend_q <= dec_evt;
            if (!brk_f) cnt_q <= cnt_q + CNT_W'(1);
         end

         if (do_load) begin
            evt_q       <= pend_q;
            evt_valid_q <= 1'b1;
         end else if (bus.evt_ready) begin
            evt_valid_q <= 1'b0;
         end
      end
   end

   ps2_mod_tracker u_mod (
      .clk       (clk),
      .clrn      (clrn),
      .strobe    (do_evt),
      .code      (dec_evt.code),
      .ext       (dec_evt.ext),
      .brk       (dec_evt.brk),
      .mod_shift (mod_shift),
      .mod_ctrl  (mod_ctrl),
      .mod_alt   (mod_alt),
      .caps_lock (caps_lock)
   );

   assign bus.kb_nextdata_n = nextdata_n_q;
   assign bus.evt_valid     = evt_valid_q;
   assign bus.evt_code      = evt_q.code;
   assign bus.evt_ext       = evt_q.ext;
   assign bus.evt_break     = evt_q.brk;
   assign key_cnt           = cnt_q;

endmodule
